jt49_bus_master: RTL and testbench
==================================

JT49_BUS_MASTER -- requirements
Module: jt49_bus_master

Interface
REQ-001 SHALL have parameter HOLD, default 2, clk cycles per active bus phase; legal range 1..15.
REQ-002 SHALL have parameter CHIP_ADDR, default 4'h0, driven on bus_dout[7:4] during the address phase.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  transfer request; sampled only while busy=0.
REQ-006 wr  input  1  1=register write, 0=register read; sampled with req.
REQ-007 addr  input  4  PSG register number; sampled with req.
REQ-008 wdata  input  8  write data; sampled with req.
REQ-009 busy  output  1  transfer in progress.
REQ-010 done  output  1  one-cycle pulse at transfer end.
REQ-011 rdata  output  8  last read result; held until the next read completes.
REQ-012 bdir, bc1  output  1 each  PSG bus control pins.
REQ-013 bus_dout  output  8  data/address driven to the PSG.
REQ-014 bus_oe  output  1  bus_dout drive enable.
REQ-015 bus_din  input  8  PSG data-out bus.

Function
REQ-016 All outputs SHALL be registered; no combinational input-to-output path.
REQ-017 FSM states SHALL be IDLE, ADDR, GAP1, DATA, GAP2.
REQ-018 In IDLE with req=1 at edge T, SHALL latch wr/addr/wdata and set busy=1 from T+1.
REQ-019 ADDR: HOLD cycles; {bdir,bc1}=11; bus_dout={CHIP_ADDR,addr}; bus_oe=1.
REQ-020 GAP1: 1 cycle; {bdir,bc1}=00; bus_oe=0.
REQ-021 DATA for a write: HOLD cycles; {bdir,bc1}=10; bus_dout=wdata; bus_oe=1.
REQ-022 DATA for a read: HOLD cycles; {bdir,bc1}=01; bus_oe=0; rdata SHALL capture bus_din on the last DATA cycle.
REQ-023 GAP2: 1 cycle; {bdir,bc1}=00; bus_oe=0; done=1; busy=1; then return to IDLE.
REQ-024 With HOLD=2 and no address skip, accept at T gives ADDR T+1..T+2, GAP1 T+3, DATA T+4..T+5, GAP2/done T+6, busy=0 at T+7.
REQ-025 A req held high continuously SHALL start the next transfer at the edge where busy=0 (back-to-back, no extra idle).
REQ-026 req/wr/addr/wdata changes while busy=1 SHALL be ignored.
REQ-027 The phase counter SHALL be 4 bits, reload HOLD-1 on phase entry, and decrement to 0.
REQ-028 bus_dout SHALL be 8'h00 whenever bus_oe=0.
REQ-029 {bdir,bc1} SHALL never move directly between two non-00 codes; every change of active code passes through 00.

Reset
REQ-030 While rst_n=0 at a clk edge: state=IDLE; busy=0; done=0; rdata=8'h00; {bdir,bc1}=00; bus_dout=8'h00; bus_oe=0; address cache invalid.
REQ-031 Reset asserted mid-transfer SHALL abort it; no done pulse; the first post-reset cycle shows all REQ-030 values.

Configuration
REQ-032 Macro JT49_ADDR_CACHE_EN SHALL control address caching.
REQ-033 When defined, SHALL store the last latched addr with a valid flag. On accept, if valid and addr matches, ADDR and GAP1 are skipped and DATA starts at T+1. Latency for HOLD=2: DATA T+1..T+2, done T+3.
REQ-034 When undefined, every transfer SHALL include ADDR and GAP1; no cache storage is synthesised.

Verification
REQ-035 Write: HOLD=2, addr=7, wdata=8'h38 -> bus 11/dout 8'h07 for 2 cycles, 00, 10/dout 8'h38 for 2 cycles, 00 with done at T+6.
REQ-036 Read: addr=14, bus_din=8'hA5 -> bus 11/dout 8'h0E, 00, 01 with bus_oe=0 for 2 cycles, done at T+6, rdata=8'hA5 from T+6.
REQ-037 Back-to-back: req held high for writes to addr 0 then 1 -> second ADDR phase starts at T+7; no 11->10 or 10->11 transition without 00.
REQ-038 Reset mid-transfer: rst_n=0 during DATA -> next cycle busy=0, {bdir,bc1}=00, no done; a fresh write then completes normally.
REQ-039 With JT49_ADDR_CACHE_EN: two writes to addr 8 -> second has no 11 phase and done at T+3; a write to addr 9 then restores the ADDR phase; after reset, addr 8 again emits the ADDR phase.
REQ-040 HOLD=1 and HOLD=15: write to addr 3 -> each active phase lasts exactly HOLD cycles; done at T+4 and T+32 respectively.

Source files
------------

// File: rtl/jt49_bus_master.sv
// Bus master that sequences register reads and writes to a JT49/AY-3-8910 PSG bus.
// Optional address caching is enabled with the macro JT49_ADDR_CACHE_EN.
`timescale 1ns/1ps

module jt49_bus_master #(
    parameter int         HOLD      = 2,
    parameter logic [3:0] CHIP_ADDR = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;

    localparam logic [3:0] RELOAD = 4'(HOLD - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic       accept;
    logic       hit;

    // GAP2 may accept directly so a held req runs back-to-back without an idle cycle
    assign accept = req && ((state == IDLE) || (state == GAP2));

`ifdef JT49_ADDR_CACHE_EN
    logic       cache_valid;
    logic [3:0] cache_addr;

    assign hit = cache_valid && (cache_addr == addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_addr  <= 4'h0;
        end else if (accept) begin
            cache_valid <= 1'b1;
            cache_addr  <= addr;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'h0;
            wr_q     <= 1'b0;
            wdata_q  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            bdir     <= 1'b0;
            bc1      <= 1'b0;
            bus_dout <= 8'h00;
            bus_oe   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, GAP2: begin
                    if (accept) begin
                        wr_q    <= wr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        cnt     <= RELOAD;
                        if (hit) begin
                            state    <= DATA;
                            bdir     <= wr;
                            bc1      <= !wr;
                            bus_dout <= wr ? wdata : 8'h00;
                            bus_oe   <= wr;
                        end else begin
                            state    <= ADDR;
                            bdir     <= 1'b1;
                            bc1      <= 1'b1;
                            bus_dout <= {CHIP_ADDR, addr};
                            bus_oe   <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bdir     <= 1'b0;
                        bc1      <= 1'b0;
                        bus_dout <= 8'h00;
                        bus_oe   <= 1'b0;
                    end
                end
                ADDR: begin
                    if (cnt == 4'h0) begin
                        state    <= GAP1;
                        bdir     <= 1'b0;
                        bc1      <= 1'b0;
                        bus_dout <= 8'h00;
                        bus_oe   <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'h1;
                    end
                end
                GAP1: begin
                    state    <= DATA;
                    cnt      <= RELOAD;
                    bdir     <= wr_q;
                    bc1      <= !wr_q;
                    bus_dout <= wr_q ? wdata_q : 8'h00;
                    bus_oe   <= wr_q;
                end
                DATA: begin
                    if (cnt == 4'h0) begin
                        if (!wr_q) rdata <= bus_din;
                        state    <= GAP2;
                        done     <= 1'b1;
                        bdir     <= 1'b0;
                        bc1      <= 1'b0;
                        bus_dout <= 8'h00;
                        bus_oe   <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'h1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt49_bus_master.sv
// Scoreboard bench for jt49_bus_master: HOLD=2, HOLD=1 and HOLD=15 instances share inputs.
// Cycle-by-cycle expectations come from a small bus model, including JT49_ADDR_CACHE_EN skipping.
`timescale 1ns/1ps

module tb_jt49_bus_master;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] ctl;
        logic       oe;
        logic [7:0] dout;
        logic [7:0] rdata;
        logic [7:0] din;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_v [3];
    logic       wr = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] bus_din = 8'h00;

    logic       busy_v [3];
    logic       done_v [3];
    logic       bdir_v [3];
    logic       bc1_v  [3];
    logic       oe_v   [3];
    logic [7:0] dout_v [3];
    logic [7:0] rdata_v[3];

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] rd_model [3];
    logic       cache_v  [3];
    logic [3:0] cache_a  [3];
    logic [1:0] prev_ctl [3];

    always #5 clk = ~clk;

    jt49_bus_master #(.HOLD(2), .CHIP_ADDR(4'h0)) u_main (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .bdir(bdir_v[0]), .bc1(bc1_v[0]),
        .bus_dout(dout_v[0]), .bus_oe(oe_v[0]), .bus_din(bus_din)
    );

    jt49_bus_master #(.HOLD(1), .CHIP_ADDR(4'hA)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .bdir(bdir_v[1]), .bc1(bc1_v[1]),
        .bus_dout(dout_v[1]), .bus_oe(oe_v[1]), .bus_din(bus_din)
    );

    jt49_bus_master #(.HOLD(15), .CHIP_ADDR(4'h0)) u_h15 (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy_v[2]), .done(done_v[2]), .rdata(rdata_v[2]), .bdir(bdir_v[2]), .bc1(bc1_v[2]),
        .bus_dout(dout_v[2]), .bus_oe(oe_v[2]), .bus_din(bus_din)
    );

    function automatic int hold_of(int w);
        return (w == 0) ? 2 : ((w == 1) ? 1 : 15);
    endfunction

    function automatic logic [3:0] chip_of(int w);
        return (w == 1) ? 4'hA : 4'h0;
    endfunction

    function automatic logic [20:0] obs(int w);
        return {busy_v[w], done_v[w], bdir_v[w], bc1_v[w], oe_v[w], dout_v[w], rdata_v[w]};
    endfunction

    task automatic reset_models();
        for (int w = 0; w < 3; w++) begin
            rd_model[w] = 8'h00;
            cache_v[w]  = 1'b0;
            cache_a[w]  = 4'h0;
            prev_ctl[w] = 2'b00;
        end
    endtask

    task automatic push_idle(int w);
        exp_t e;
        e = '0;
        e.rdata = rd_model[w];
        sb.push_back(e);
    endtask

    // Expected bus activity for one accepted transfer; the cache model decides whether ADDR/GAP1 appear
    task automatic push_transfer(int w, logic t_wr, logic [3:0] a, logic [7:0] wd, logic [7:0] din);
        exp_t e;
        bit   skip;
        int   hold;
        hold = hold_of(w);
        skip = 1'b0;
`ifdef JT49_ADDR_CACHE_EN
        skip = cache_v[w] && (cache_a[w] == a);
        cache_v[w] = 1'b1;
        cache_a[w] = a;
`endif
        if (!skip) begin
            for (int i = 0; i < hold; i++) begin
                e = '0;
                e.busy = 1'b1; e.ctl = 2'b11; e.oe = 1'b1;
                e.dout = {chip_of(w), a}; e.rdata = rd_model[w]; e.din = ~din;
                sb.push_back(e);
            end
            e = '0;
            e.busy = 1'b1; e.rdata = rd_model[w]; e.din = ~din;
            sb.push_back(e);
        end
        for (int i = 0; i < hold; i++) begin
            e = '0;
            e.busy = 1'b1;
            e.ctl  = t_wr ? 2'b10 : 2'b01;
            e.oe   = t_wr;
            e.dout = t_wr ? wd : 8'h00;
            e.rdata = rd_model[w];
            e.din  = (i == hold - 1) ? din : ~din;
            sb.push_back(e);
        end
        if (!t_wr) rd_model[w] = din;
        e = '0;
        e.busy = 1'b1; e.done = 1'b1; e.rdata = rd_model[w];
        sb.push_back(e);
    endtask

    task automatic drain(int w, int n);
        exp_t       e;
        logic [20:0] o;
        logic [20:0] x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_empty: dut%0d observed output with no expectation queued", w);
                return;
            end
            e = sb.pop_front();
            bus_din = e.din;
            o = obs(w);
            x = {e.busy, e.done, e.ctl, e.oe, e.dout, e.rdata};
            if (o !== x) begin
                failures++;
                $display("[TB] FAIL cycle_dut%0d @%0t: busy/done/ctl/oe/dout/rdata got %b/%b/%b/%b/%h/%h want %b/%b/%b/%b/%h/%h",
                         w, $time, o[20], o[19], o[18:17], o[16], o[15:8], o[7:0],
                         x[20], x[19], x[18:17], x[16], x[15:8], x[7:0]);
            end
            checks++;
            if ((prev_ctl[w] != 2'b00) && (o[18:17] != 2'b00) && (o[18:17] != prev_ctl[w])) begin
                failures++;
                $display("[TB] FAIL ctl_transition_dut%0d @%0t: got %b after %b, required a 00 in between",
                         w, $time, o[18:17], prev_ctl[w]);
            end
            prev_ctl[w] = o[18:17];
        end
    endtask

    task automatic start(int w, logic t_wr, logic [3:0] a, logic [7:0] wd, logic [7:0] din, bit keep);
        @(negedge clk);
        req_v[w] = 1'b1;
        wr = t_wr; addr = a; wdata = wd;
        push_transfer(w, t_wr, a, wd, din);
        @(posedge clk);
        #1;
        if (!keep) begin
            req_v[w] = 1'b0;
            wr = ~t_wr; addr = ~a; wdata = ~wd;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (obs(w) !== 21'h0) begin
                failures++;
                $display("[TB] FAIL reset_state_dut%0d: got %h want 000000", w, obs(w));
            end
        end
        rst_n = 1'b1;
        reset_models();
        push_idle(0);
        drain(0, 1);
    endtask

    task automatic test_write();
        start(0, 1'b1, 4'd7, 8'h38, 8'h00, 1'b0);
        push_idle(0);
        drain(0, sb.size());
    endtask

    task automatic test_read();
        start(0, 1'b0, 4'd14, 8'h00, 8'hA5, 1'b0);
        push_idle(0);
        drain(0, sb.size());
    endtask

    task automatic test_back_to_back();
        start(0, 1'b1, 4'd0, 8'h11, 8'h00, 1'b1);
        wr = 1'b1; addr = 4'd1; wdata = 8'h22;
        push_transfer(0, 1'b1, 4'd1, 8'h22, 8'h00);
        drain(0, 7);
        req_v[0] = 1'b0;
        push_idle(0);
        drain(0, sb.size());
    endtask

    task automatic test_reset_mid();
        start(0, 1'b1, 4'd5, 8'h5C, 8'h00, 1'b0);
        drain(0, 4);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_models();
        push_idle(0);
        push_idle(0);
        drain(0, 2);
        start(0, 1'b1, 4'd5, 8'h5C, 8'h00, 1'b0);
        push_idle(0);
        drain(0, sb.size());
    endtask

    task automatic test_hold_extremes();
        for (int w = 1; w < 3; w++) begin
            start(w, 1'b1, 4'd3, 8'h3C, 8'h00, 1'b0);
            push_idle(w);
            drain(w, sb.size());
        end
    endtask

    task automatic test_addr_cache();
        start(0, 1'b1, 4'd8, 8'h81, 8'h00, 1'b0);
        push_idle(0);
        drain(0, sb.size());
        start(0, 1'b1, 4'd8, 8'h82, 8'h00, 1'b0);
        push_idle(0);
        drain(0, sb.size());
        start(0, 1'b1, 4'd9, 8'h93, 8'h00, 1'b0);
        push_idle(0);
        drain(0, sb.size());
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_models();
        start(0, 1'b1, 4'd8, 8'h84, 8'h00, 1'b0);
        push_idle(0);
        drain(0, sb.size());
    endtask

    initial begin
        for (int w = 0; w < 3; w++) req_v[w] = 1'b0;
        reset_models();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_hold_extremes();
        test_addr_cache();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
